hram_wb_arbiter: RTL and testbench
==================================

HRAM_WB_ARBITER -- requirements
Module: hram_wb_arbiter

Interface
REQ-001 Parameter NM, default 3, number of Wishbone masters (index 0 = CPU, 1 = SD controller, 2 = camera streamer).
REQ-002 Parameter AW, default 32, address width.
REQ-003 Parameter DW, default 32, data width; select width is DW/8.
REQ-004 Parameter MAX_BEATS, default 64, acked beats a grant may take before it is flagged for release at the next cycle boundary.
REQ-005 wb_clk_i  in  1  sole clock; all state is updated on its rising edge.
REQ-006 wb_rst_i  in  1  reset, synchronous, active-high.
REQ-007 wbm_adr_i / wbm_dat_i  in  NM*AW / NM*DW  packed master address / write data.
REQ-008 wbm_sel_i  in  NM*DW/8  packed byte selects.
REQ-009 wbm_we_i, wbm_cyc_i, wbm_stb_i  in  NM each  per-master write, cycle, strobe.
REQ-010 wbm_cti_i / wbm_bte_i  in  NM*3 / NM*2  per-master burst type.
REQ-011 wbm_dat_o  out  DW  slave read data, broadcast to all masters.
REQ-012 wbm_ack_o  out  NM  per-master acknowledge.
REQ-013 wbs_adr_o, wbs_dat_o, wbs_sel_o, wbs_we_o, wbs_cyc_o, wbs_stb_o, wbs_cti_o, wbs_bte_o  out  AW, DW, DW/8, 1, 1, 1, 3, 2  to the HyperRAM data port.
REQ-014 wbs_dat_i, wbs_ack_i  in  DW, 1  from the HyperRAM data port.
REQ-015 grant_o  out  NM  one-hot current owner, all-zero when idle.
REQ-016 overrun_o  out  1  one-cycle pulse when a grant reaches MAX_BEATS.

Function
REQ-017 The state machine SHALL have states IDLE, OWN and GAP.
REQ-018 In IDLE with any wbm_cyc_i high, the arbiter SHALL register a one-hot grant and enter OWN on the next edge; it SHALL never grant a master whose cyc is low.
REQ-019 Winner selection SHALL be round-robin starting at index (last_owner+1) mod NM; after reset, last_owner = NM-1, so master 0 wins the first contention.
REQ-020 In OWN, all wbs_* outputs SHALL be a combinational mux of the granted master's inputs; when no master is granted, wbs_cyc_o and wbs_stb_o SHALL be 0.
REQ-021 wbm_ack_o[i] SHALL equal wbs_ack_i AND grant_o[i]; non-owners SHALL never see ack.
REQ-022 OWN SHALL go to GAP when the owner's cyc falls.
REQ-023 GAP SHALL last exactly one cycle with wbs_cyc_o = 0, then go to IDLE, so the slave always sees cyc low between owners.
REQ-024 Arbitration latency SHALL be 1 cycle from IDLE; back-to-back owners SHALL see 3 cycles between the old owner's cyc fall and the new owner's first slave strobe.
REQ-025 A beat counter SHALL count owner acks (saturating at MAX_BEATS) and clear on entering OWN.
REQ-026 Reaching MAX_BEATS SHALL pulse overrun_o once but SHALL NOT remove the grant, since Wishbone cycles are never cut; the owner keeps the grant until its cyc falls.
REQ-027 An owner's cyc falling in the same cycle as wbs_ack_i SHALL still deliver that ack to it.
REQ-028 Requests that rise in OWN or GAP SHALL wait and be arbitrated in the next IDLE.
REQ-029 A burst (cti 001/010) SHALL stay with one owner until its cyc falls, regardless of the cti 111 end-of-burst beat.

Reset
REQ-030 While wb_rst_i is high, at the next edge: state = IDLE, grant_o = 0, last_owner = NM-1, beat counter = 0, overrun_o = 0, wbs_cyc_o = wbs_stb_o = 0, wbm_ack_o = 0.
REQ-031 Reset asserted mid-burst SHALL drop the grant at once.
REQ-032 The arbiter SHALL NOT wait for the slave to finish when reset asserts; the slave is reset by the same wb_rst_i.

Structure
REQ-033 The state encoding, master index constants (IDX_CPU = 0, IDX_SDC = 1, IDX_CAM = 2) and cti codes SHALL live in the shared package hram_pkg.
REQ-034 The round-robin picker SHALL be the one sub-module rr_pick (request vector plus last owner in, one-hot out, purely combinational).
REQ-035 Total RTL SHALL be 120-400 lines.

Verification
REQ-036 Single request: m1 cyc/stb at cycle 0 -> grant_o = 010 at cycle 1; wbs_adr_o = m1 address; ack seen only on wbm_ack_o[1].
REQ-037 Simultaneous requests: all three masters request after reset -> grants in order 001, 010, 100, each separated by one GAP cycle with wbs_cyc_o = 0.
REQ-038 Burst: m2 issues an 8-beat cti 010 burst while m0 requests -> m0 is granted only after m2's cyc falls; exactly 8 acks reach m2 and none reach m0.
REQ-039 Overrun: MAX_BEATS = 4 and m1 holds a 6-beat burst -> overrun_o pulses once on the 4th ack; m1 receives all 6 acks.
REQ-040 Reset mid-burst: wb_rst_i high on beat 3 of m0's burst -> next edge grant_o = 0, wbs_cyc_o = 0; the first grant after release goes to m0.
REQ-041 Cyc drop with ack: m0 drops cyc in the same cycle as wbs_ack_i -> wbm_ack_o[0] = 1 that cycle; state = GAP next cycle.

Source files
------------

// File: rtl/hram_pkg.sv
// Shared definitions for the HyperRAM Wishbone arbiter: FSM encoding,
// master index assignments and Wishbone burst cycle-type codes.
package hram_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN  = 2'd1,
    ST_GAP  = 2'd2
  } arb_state_t;

  localparam int IDX_CPU = 0;
  localparam int IDX_SDC = 1;
  localparam int IDX_CAM = 2;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_CONST   = 3'b001;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  // Width of an index into n masters, never less than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/hram_wb_arbiter_rr_pick.sv
// Round-robin picker: scans requesters starting one past the last owner
// and returns a one-hot winner, all-zero when nobody requests.
module rr_pick
  import hram_pkg::*;
#(
  parameter int NM = 3,
  parameter int LW = idx_w(NM)
) (
  input  logic [NM-1:0] i_req,
  input  logic [LW-1:0] i_last,
  output logic [NM-1:0] o_gnt
);

  logic          w_found;
  logic [LW-1:0] w_idx;

  // First requester found at offsets last+1 .. last+NM wins.
  always_comb begin
    o_gnt   = '0;
    w_found = 1'b0;
    w_idx   = '0;
    for (int k = 1; k <= NM; k++) begin
      w_idx = LW'((int'(i_last) + k) % NM);
      if (!w_found && i_req[w_idx]) begin
        o_gnt[w_idx] = 1'b1;
        w_found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/hram_wb_arbiter.sv
// Wishbone arbiter sharing the HyperRAM data port between NM masters.
// A grant is held for the owner's whole cycle; a one-cycle gap with
// cyc low always separates consecutive owners.
//
// state   | meaning
// --------+---------------------------------------------------------
// IDLE    | no owner; any cyc high is arbitrated on the next edge
// OWN     | granted master is muxed onto the slave port
// GAP     | one cycle with slave cyc low before returning to IDLE
module hram_wb_arbiter
  import hram_pkg::*;
#(
  parameter int NM        = 3,
  parameter int AW        = 32,
  parameter int DW        = 32,
  parameter int MAX_BEATS = 64
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_i,
  input  logic [NM*AW-1:0]    wbm_adr_i,
  input  logic [NM*DW-1:0]    wbm_dat_i,
  input  logic [NM*DW/8-1:0]  wbm_sel_i,
  input  logic [NM-1:0]       wbm_we_i,
  input  logic [NM-1:0]       wbm_cyc_i,
  input  logic [NM-1:0]       wbm_stb_i,
  input  logic [NM*3-1:0]     wbm_cti_i,
  input  logic [NM*2-1:0]     wbm_bte_i,
  output logic [DW-1:0]       wbm_dat_o,
  output logic [NM-1:0]       wbm_ack_o,
  output logic [AW-1:0]       wbs_adr_o,
  output logic [DW-1:0]       wbs_dat_o,
  output logic [DW/8-1:0]     wbs_sel_o,
  output logic                wbs_we_o,
  output logic                wbs_cyc_o,
  output logic                wbs_stb_o,
  output logic [2:0]          wbs_cti_o,
  output logic [1:0]          wbs_bte_o,
  input  logic [DW-1:0]       wbs_dat_i,
  input  logic                wbs_ack_i,
  output logic [NM-1:0]       grant_o,
  output logic                overrun_o
);

  localparam int LW = idx_w(NM);
  localparam int SW = DW / 8;
  localparam int BW = $clog2(MAX_BEATS + 1);

  arb_state_t    r_state, w_state_nxt;
  logic [NM-1:0] r_grant, w_grant_nxt;
  logic [LW-1:0] r_last, w_last_nxt;
  logic [BW-1:0] r_beats, w_beats_nxt;
  logic          r_overrun, w_overrun_nxt;

  logic [NM-1:0] w_pick;
  logic [LW-1:0] w_pick_idx;
  logic          w_owner_cyc;

  rr_pick #(.NM(NM), .LW(LW)) u_rr_pick (
    .i_req  (wbm_cyc_i),
    .i_last (r_last),
    .o_gnt  (w_pick)
  );

  // One-hot winner to index, remembered as the next round-robin origin.
  always_comb begin
    w_pick_idx = '0;
    for (int i = 0; i < NM; i++) begin
      if (w_pick[i]) w_pick_idx = LW'(i);
    end
  end

  assign w_owner_cyc = |(wbm_cyc_i & r_grant);

  // Slave port follows the granted master; zero grant forces cyc/stb low.
  always_comb begin
    wbs_adr_o = '0;
    wbs_dat_o = '0;
    wbs_sel_o = '0;
    wbs_we_o  = 1'b0;
    wbs_cyc_o = 1'b0;
    wbs_stb_o = 1'b0;
    wbs_cti_o = '0;
    wbs_bte_o = '0;
    for (int i = 0; i < NM; i++) begin
      if (r_grant[i]) begin
        wbs_adr_o = wbm_adr_i[i*AW +: AW];
        wbs_dat_o = wbm_dat_i[i*DW +: DW];
        wbs_sel_o = wbm_sel_i[i*SW +: SW];
        wbs_we_o  = wbm_we_i[i];
        wbs_cyc_o = wbm_cyc_i[i];
        wbs_stb_o = wbm_stb_i[i];
        wbs_cti_o = wbm_cti_i[i*3 +: 3];
        wbs_bte_o = wbm_bte_i[i*2 +: 2];
      end
    end
  end

  assign wbm_dat_o = wbs_dat_i;
  assign wbm_ack_o = {NM{wbs_ack_i}} & r_grant;
  assign grant_o   = r_grant;
  assign overrun_o = r_overrun;

  // Next-state logic; the beat limit only flags, it never revokes a grant.
  always_comb begin
    w_state_nxt   = r_state;
    w_grant_nxt   = r_grant;
    w_last_nxt    = r_last;
    w_beats_nxt   = r_beats;
    w_overrun_nxt = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (|wbm_cyc_i) begin
          w_state_nxt = ST_OWN;
          w_grant_nxt = w_pick;
          w_last_nxt  = w_pick_idx;
          w_beats_nxt = '0;
        end
      end
      ST_OWN: begin
        if (wbs_ack_i && (r_beats != BW'(MAX_BEATS))) begin
          w_beats_nxt   = r_beats + BW'(1);
          w_overrun_nxt = (r_beats == BW'(MAX_BEATS - 1));
        end
        if (!w_owner_cyc) begin
          w_state_nxt = ST_GAP;
          w_grant_nxt = '0;
        end
      end
      ST_GAP: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_grant_nxt = '0;
      end
    endcase
  end

  // State registers; reset drops the grant immediately, even mid-burst.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_state   <= ST_IDLE;
      r_grant   <= '0;
      r_last    <= LW'(NM - 1);
      r_beats   <= '0;
      r_overrun <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_grant   <= w_grant_nxt;
      r_last    <= w_last_nxt;
      r_beats   <= w_beats_nxt;
      r_overrun <= w_overrun_nxt;
    end
  end

endmodule

// File: tb/tb_hram_wb_arbiter.sv
// Bench for hram_wb_arbiter: directed scenarios plus a randomized run
// checked against a cycle-level reference model of the arbitration rules.
module tb_hram_wb_arbiter;
  import hram_pkg::*;

  localparam int NM = 3;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MB = 4;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic [NM*AW-1:0]   m_adr = '0;
  logic [NM*DW-1:0]   m_dat = '0;
  logic [NM*DW/8-1:0] m_sel = '0;
  logic [NM-1:0]      m_we  = '0;
  logic [NM-1:0]      m_cyc = '0;
  logic [NM-1:0]      m_stb = '0;
  logic [NM*3-1:0]    m_cti = '0;
  logic [NM*2-1:0]    m_bte = '0;
  logic [DW-1:0]      s_dat_i = '0;
  logic               s_ack = 1'b0;

  logic [DW-1:0]      wbm_dat_o;
  logic [NM-1:0]      wbm_ack_o;
  logic [AW-1:0]      wbs_adr_o;
  logic [DW-1:0]      wbs_dat_o;
  logic [DW/8-1:0]    wbs_sel_o;
  logic               wbs_we_o, wbs_cyc_o, wbs_stb_o;
  logic [2:0]         wbs_cti_o;
  logic [1:0]         wbs_bte_o;
  logic [NM-1:0]      grant_o;
  logic               overrun_o;

  int n_cmp = 0;
  int n_mis = 0;

  hram_wb_arbiter #(.NM(NM), .AW(AW), .DW(DW), .MAX_BEATS(MB)) dut (
    .wb_clk_i (clk),       .wb_rst_i (rst),
    .wbm_adr_i(m_adr),     .wbm_dat_i(m_dat),     .wbm_sel_i(m_sel),
    .wbm_we_i (m_we),      .wbm_cyc_i(m_cyc),     .wbm_stb_i(m_stb),
    .wbm_cti_i(m_cti),     .wbm_bte_i(m_bte),
    .wbm_dat_o(wbm_dat_o), .wbm_ack_o(wbm_ack_o),
    .wbs_adr_o(wbs_adr_o), .wbs_dat_o(wbs_dat_o), .wbs_sel_o(wbs_sel_o),
    .wbs_we_o (wbs_we_o),  .wbs_cyc_o(wbs_cyc_o), .wbs_stb_o(wbs_stb_o),
    .wbs_cti_o(wbs_cti_o), .wbs_bte_o(wbs_bte_o),
    .wbs_dat_i(s_dat_i),   .wbs_ack_i(s_ack),
    .grant_o  (grant_o),   .overrun_o(overrun_o)
  );

  always #5 clk = ~clk;

  task automatic edge_t();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_master(input int m, input logic cyc, input logic [31:0] adr,
                              input logic [2:0] cti);
    m_cyc[m]             = cyc;
    m_stb[m]             = cyc;
    m_adr[m*AW +: AW]    = adr;
    m_dat[m*DW +: DW]    = ~adr;
    m_sel[m*4 +: 4]      = adr[7:4];
    m_we[m]              = adr[0];
    m_cti[m*3 +: 3]      = cti;
    m_bte[m*2 +: 2]      = adr[9:8];
  endtask

  task automatic apply_reset();
    rst   = 1'b1;
    m_cyc = '0;
    m_stb = '0;
    s_ack = 1'b0;
    edge_t();
    edge_t();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    m_cyc = '1;
    m_stb = '1;
    s_ack = 1'b1;
    edge_t();
    edge_t();
    n_cmp++; if (grant_o !== 3'b000) begin n_mis++; $display("FAIL reset_grant: got %b want 000", grant_o); end
    n_cmp++; if (wbs_cyc_o !== 1'b0 || wbs_stb_o !== 1'b0) begin n_mis++; $display("FAIL reset_cyc_stb: got %b%b want 00", wbs_cyc_o, wbs_stb_o); end
    n_cmp++; if (wbm_ack_o !== 3'b000) begin n_mis++; $display("FAIL reset_ack: got %b want 000", wbm_ack_o); end
    n_cmp++; if (overrun_o !== 1'b0) begin n_mis++; $display("FAIL reset_overrun: got %b want 0", overrun_o); end
    m_cyc = '0;
    m_stb = '0;
    s_ack = 1'b0;
    rst   = 1'b0;
  endtask

  task automatic test_single();
    apply_reset();
    drive_master(IDX_SDC, 1'b1, 32'hA5A5_0040, CTI_CLASSIC);
    s_dat_i = 32'h1234_5678;
    edge_t();
    n_cmp++; if (grant_o !== 3'b010) begin n_mis++; $display("FAIL single_grant: got %b want 010", grant_o); end
    n_cmp++; if (wbs_adr_o !== 32'hA5A5_0040) begin n_mis++; $display("FAIL single_adr: got %h want a5a50040", wbs_adr_o); end
    n_cmp++; if (wbs_dat_o !== 32'h5A5A_FFBF || wbs_sel_o !== 4'h4 || wbs_we_o !== 1'b0)
      begin n_mis++; $display("FAIL single_mux: got dat %h sel %h we %b want 5a5affbf 4 0", wbs_dat_o, wbs_sel_o, wbs_we_o); end
    s_ack = 1'b1;
    #1;
    n_cmp++; if (wbm_ack_o !== 3'b010) begin n_mis++; $display("FAIL single_ack: got %b want 010", wbm_ack_o); end
    n_cmp++; if (wbm_dat_o !== 32'h1234_5678) begin n_mis++; $display("FAIL single_rdata: got %h want 12345678", wbm_dat_o); end
    edge_t();
    s_ack = 1'b0;
    drive_master(IDX_SDC, 1'b0, 32'h0, CTI_CLASSIC);
    edge_t();
    n_cmp++; if (grant_o !== 3'b000 || wbs_cyc_o !== 1'b0) begin n_mis++; $display("FAIL single_gap: got grant %b cyc %b want 000 0", grant_o, wbs_cyc_o); end
  endtask

  task automatic test_simultaneous();
    logic [2:0] exp;
    apply_reset();
    for (int m = 0; m < NM; m++) drive_master(m, 1'b1, 32'h1000_0000 + 32'(m * 16), CTI_CLASSIC);
    for (int n = 0; n < NM; n++) begin
      edge_t();
      exp = 3'b001 << n;
      n_cmp++; if (grant_o !== exp || wbs_stb_o !== 1'b1) begin n_mis++; $display("FAIL simul_grant%0d: got %b stb %b want %b 1", n, grant_o, wbs_stb_o, exp); end
      n_cmp++; if (wbs_adr_o !== 32'h1000_0000 + 32'(n * 16)) begin n_mis++; $display("FAIL simul_adr%0d: got %h want %h", n, wbs_adr_o, 32'h1000_0000 + 32'(n * 16)); end
      s_ack = 1'b1;
      #1;
      n_cmp++; if (wbm_ack_o !== exp) begin n_mis++; $display("FAIL simul_ack%0d: got %b want %b", n, wbm_ack_o, exp); end
      edge_t();
      s_ack = 1'b0;
      drive_master(n, 1'b0, 32'h0, CTI_CLASSIC);
      edge_t();
      n_cmp++; if (grant_o !== 3'b000 || wbs_cyc_o !== 1'b0) begin n_mis++; $display("FAIL simul_gap%0d: got grant %b cyc %b want 000 0", n, grant_o, wbs_cyc_o); end
      edge_t();
      n_cmp++; if (grant_o !== 3'b000) begin n_mis++; $display("FAIL simul_idle%0d: got %b want 000", n, grant_o); end
    end
  endtask

  task automatic test_burst();
    int acks2, acks0, ov;
    logic held;
    apply_reset();
    drive_master(IDX_CAM, 1'b1, 32'h2000_0000, CTI_INCR);
    edge_t();
    drive_master(IDX_CPU, 1'b1, 32'h0000_0100, CTI_CLASSIC);
    acks2 = 0; acks0 = 0; ov = 0; held = 1'b1;
    for (int t = 0; t < 200 && acks2 < 8; t++) begin
      m_cti[IDX_CAM*3 +: 3] = (acks2 == 7) ? CTI_EOB : CTI_INCR;
      s_ack = 1'($urandom_range(0, 1));
      #1;
      if (wbm_ack_o[IDX_CAM]) acks2++;
      if (wbm_ack_o[IDX_CPU]) acks0++;
      if (grant_o !== 3'b100) held = 1'b0;
      edge_t();
      if (overrun_o) ov++;
    end
    s_ack = 1'b0;
    drive_master(IDX_CAM, 1'b0, 32'h0, CTI_CLASSIC);
    n_cmp++; if (acks2 != 8) begin n_mis++; $display("FAIL burst_m2_acks: got %0d want 8", acks2); end
    n_cmp++; if (acks0 != 0) begin n_mis++; $display("FAIL burst_m0_acks: got %0d want 0", acks0); end
    n_cmp++; if (held !== 1'b1) begin n_mis++; $display("FAIL burst_grant_held: got %b want 1", held); end
    edge_t();
    if (overrun_o) ov++;
    n_cmp++; if (ov != 1) begin n_mis++; $display("FAIL burst_overrun_pulses: got %0d want 1", ov); end
    n_cmp++; if (grant_o !== 3'b000) begin n_mis++; $display("FAIL burst_gap: got %b want 000", grant_o); end
    edge_t();
    edge_t();
    n_cmp++; if (grant_o !== 3'b001) begin n_mis++; $display("FAIL burst_next_owner: got %b want 001", grant_o); end
  endtask

  task automatic test_overrun();
    int ov_cnt, ov_beat, acks;
    apply_reset();
    drive_master(IDX_SDC, 1'b1, 32'h3000_0000, CTI_INCR);
    edge_t();
    ov_cnt = 0; ov_beat = -1; acks = 0;
    for (int b = 0; b < 6; b++) begin
      m_cti[IDX_SDC*3 +: 3] = (b == 5) ? CTI_EOB : CTI_INCR;
      s_ack = 1'b1;
      #1;
      if (wbm_ack_o[IDX_SDC]) acks++;
      edge_t();
      if (overrun_o) begin ov_cnt++; ov_beat = b; end
    end
    s_ack = 1'b0;
    n_cmp++; if (ov_cnt != 1) begin n_mis++; $display("FAIL overrun_count: got %0d want 1", ov_cnt); end
    n_cmp++; if (ov_beat != 3) begin n_mis++; $display("FAIL overrun_beat: got %0d want 3", ov_beat); end
    n_cmp++; if (acks != 6) begin n_mis++; $display("FAIL overrun_acks: got %0d want 6", acks); end
    n_cmp++; if (grant_o !== 3'b010) begin n_mis++; $display("FAIL overrun_grant_kept: got %b want 010", grant_o); end
    drive_master(IDX_SDC, 1'b0, 32'h0, CTI_CLASSIC);
    edge_t();
  endtask

  task automatic test_reset_mid();
    apply_reset();
    drive_master(IDX_CPU, 1'b1, 32'h4000_0000, CTI_INCR);
    edge_t();
    s_ack = 1'b1;
    edge_t();
    edge_t();
    rst = 1'b1;
    drive_master(IDX_SDC, 1'b1, 32'h4100_0000, CTI_CLASSIC);
    drive_master(IDX_CAM, 1'b1, 32'h4200_0000, CTI_CLASSIC);
    edge_t();
    n_cmp++; if (grant_o !== 3'b000 || wbs_cyc_o !== 1'b0) begin n_mis++; $display("FAIL rstmid_drop: got grant %b cyc %b want 000 0", grant_o, wbs_cyc_o); end
    n_cmp++; if (wbm_ack_o !== 3'b000) begin n_mis++; $display("FAIL rstmid_ack: got %b want 000", wbm_ack_o); end
    rst   = 1'b0;
    s_ack = 1'b0;
    edge_t();
    n_cmp++; if (grant_o !== 3'b001) begin n_mis++; $display("FAIL rstmid_first_grant: got %b want 001", grant_o); end
  endtask

  task automatic test_cyc_drop_ack();
    apply_reset();
    drive_master(IDX_CPU, 1'b1, 32'h5000_0000, CTI_CLASSIC);
    edge_t();
    drive_master(IDX_CPU, 1'b0, 32'h5000_0000, CTI_CLASSIC);
    drive_master(IDX_SDC, 1'b1, 32'h5100_0000, CTI_CLASSIC);
    s_ack = 1'b1;
    #1;
    n_cmp++; if (wbm_ack_o !== 3'b001) begin n_mis++; $display("FAIL dropack_ack: got %b want 001", wbm_ack_o); end
    edge_t();
    s_ack = 1'b0;
    n_cmp++; if (grant_o !== 3'b000 || wbs_cyc_o !== 1'b0) begin n_mis++; $display("FAIL dropack_gap: got grant %b cyc %b want 000 0", grant_o, wbs_cyc_o); end
    edge_t();
    n_cmp++; if (grant_o !== 3'b000) begin n_mis++; $display("FAIL dropack_idle: got %b want 000", grant_o); end
    edge_t();
    n_cmp++; if (grant_o !== 3'b010) begin n_mis++; $display("FAIL dropack_next: got %b want 010", grant_o); end
  endtask

  // Reference: owner/last as master numbers, a one-cycle cool-down after
  // each release, and a beat tally that flags the MB-th ack.
  task automatic test_random();
    int owner, gap, last, beats, cand;
    logic exp_ov, ack_v, exp_cyc;
    int target[NM];
    int got[NM];
    logic [NM-1:0] exp_grant, exp_ack;
    apply_reset();
    owner = -1; gap = 0; last = NM - 1; beats = 0; exp_ov = 1'b0;
    for (int m = 0; m < NM; m++) begin target[m] = 0; got[m] = 0; end
    for (int t = 0; t < 600; t++) begin
      for (int m = 0; m < NM; m++) begin
        if (m_cyc[m] && owner == m && got[m] >= target[m])
          drive_master(m, 1'b0, $urandom, CTI_CLASSIC);
        else if (!m_cyc[m] && $urandom_range(0, 3) == 0) begin
          target[m] = $urandom_range(1, 6);
          got[m]    = 0;
          drive_master(m, 1'b1, $urandom, CTI_INCR);
        end else if (m_cyc[m])
          m_adr[m*AW +: AW] = $urandom;
      end
      exp_cyc   = (owner >= 0) ? m_cyc[owner] : 1'b0;
      ack_v     = exp_cyc ? 1'($urandom_range(0, 1)) : 1'b0;
      s_ack     = ack_v;
      s_dat_i   = $urandom;
      exp_grant = (owner >= 0) ? (3'b001 << owner) : 3'b000;
      exp_ack   = ack_v ? exp_grant : 3'b000;
      #1;
      n_cmp++; if (grant_o !== exp_grant) begin n_mis++; $display("FAIL rand_grant t=%0d: got %b want %b", t, grant_o, exp_grant); end
      n_cmp++; if (wbm_ack_o !== exp_ack) begin n_mis++; $display("FAIL rand_ack t=%0d: got %b want %b", t, wbm_ack_o, exp_ack); end
      n_cmp++; if (wbs_cyc_o !== exp_cyc) begin n_mis++; $display("FAIL rand_cyc t=%0d: got %b want %b", t, wbs_cyc_o, exp_cyc); end
      n_cmp++; if (overrun_o !== exp_ov) begin n_mis++; $display("FAIL rand_overrun t=%0d: got %b want %b", t, overrun_o, exp_ov); end
      if (owner >= 0) begin
        n_cmp++; if (wbs_adr_o !== m_adr[owner*AW +: AW]) begin n_mis++; $display("FAIL rand_adr t=%0d: got %h want %h", t, wbs_adr_o, m_adr[owner*AW +: AW]); end
      end
      exp_ov = 1'b0;
      if (owner >= 0) begin
        if (ack_v) begin
          got[owner]++;
          if (beats < MB) begin
            beats++;
            if (beats == MB) exp_ov = 1'b1;
          end
        end
        if (!m_cyc[owner]) begin
          owner = -1;
          gap   = 1;
        end
      end else if (gap != 0) begin
        gap = 0;
      end else if (m_cyc != '0) begin
        for (int k = 1; k <= NM; k++) begin
          cand = (last + k) % NM;
          if (owner < 0 && m_cyc[cand]) owner = cand;
        end
        last  = owner;
        beats = 0;
      end
      edge_t();
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_simultaneous();
    test_burst();
    test_overrun();
    test_reset_mid();
    test_cyc_drop_ack();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
